hid_report_parser: RTL and testbench

Host-side counterpart of the HID report manager. It consumes the 3-byte boot-protocol mouse report byte stream, reassembles frames, and validates them. It presents each report as decoded buttons and deltas behind a valid/ready handshake, and keeps a clamped absolute cursor position. It is used as the loopback checker in the 48 MHz domain and as the report sink in host-emulation builds.

---
 rtl/hid_report_parser.sv | 140 ++++++++++++++
 tb/tb_hid_report_parser.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hid_report_parser.sv
// HID boot-protocol mouse report parser: reassembles 3-byte frames,
// validates them, and tracks a clamped absolute cursor position.
module hid_report_parser #(
    parameter int TIMEOUT_CYC = 48000,
    parameter int POS_W       = 12,
    parameter int MAX_X       = 1919,
    parameter int MAX_Y       = 1079
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       rx_data,
    input  logic             rx_valid,
    output logic             rx_ready,
    output logic             report_valid,
    input  logic             report_ready,
    output logic [2:0]       buttons,
    output logic [7:0]       dx,
    output logic [7:0]       dy,
    output logic [2:0]       btn_press,
    output logic [POS_W-1:0] pos_x,
    output logic [POS_W-1:0] pos_y,
    input  logic             home,
    output logic [7:0]       err_count
);

    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CW-1:0] T_LAST = CW'(TIMEOUT_CYC - 1);
    localparam logic signed [POS_W+1:0] LIM_X = (POS_W + 2)'(MAX_X);
    localparam logic signed [POS_W+1:0] LIM_Y = (POS_W + 2)'(MAX_Y);

    typedef enum logic [1:0] {
        WAIT_BTN,
        WAIT_X,
        WAIT_Y,
        HOLD
    } state_t;

    state_t        state;
    logic [CW-1:0] tcnt;
    logic [2:0]    btn_stg;
    logic [2:0]    prev_buttons;
    logic [7:0]    dx_stg;
    logic          xfer;
    logic          tout;

    assign xfer = rx_valid && rx_ready;
    assign tout = !xfer && (tcnt == T_LAST);

    // Signed add at POS_W+2 bits so both underflow and overflow are visible
    function automatic logic [POS_W-1:0] step(
        input logic [POS_W-1:0]        pos,
        input logic [7:0]              d,
        input logic signed [POS_W+1:0] lim
    );
        logic signed [POS_W+1:0] sum;
        sum = $signed({2'b00, pos}) + $signed({{(POS_W - 6){d[7]}}, d});
        if (sum < 0)
            return '0;
        else if (sum > lim)
            return lim[POS_W-1:0];
        else
            return sum[POS_W-1:0];
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= WAIT_BTN;
            tcnt         <= '0;
            btn_stg      <= '0;
            dx_stg       <= '0;
            prev_buttons <= '0;
            rx_ready     <= 1'b1;
            report_valid <= 1'b0;
            buttons      <= '0;
            dx           <= '0;
            dy           <= '0;
            btn_press    <= '0;
            pos_x        <= '0;
            pos_y        <= '0;
            err_count    <= '0;
        end else begin
            btn_press <= '0;
            unique case (state)
                WAIT_BTN: begin
                    tcnt <= '0;
                    if (xfer) begin
                        if (rx_data[7:3] != 5'd0) begin
                            if (err_count != 8'hFF)
                                err_count <= err_count + 8'd1;
                        end else begin
                            btn_stg <= rx_data[2:0];
                            state   <= WAIT_X;
                        end
                    end
                end
                WAIT_X, WAIT_Y: begin
                    if (xfer) begin
                        tcnt <= '0;
                        if (state == WAIT_X) begin
                            dx_stg <= rx_data;
                            state  <= WAIT_Y;
                        end else begin
                            buttons      <= btn_stg;
                            dx           <= dx_stg;
                            dy           <= rx_data;
                            btn_press    <= btn_stg & ~prev_buttons;
                            prev_buttons <= btn_stg;
                            pos_x        <= step(pos_x, dx_stg, LIM_X);
                            pos_y        <= step(pos_y, rx_data, LIM_Y);
                            rx_ready     <= 1'b0;
                            report_valid <= 1'b1;
                            state        <= HOLD;
                        end
                    end else if (tout) begin
                        tcnt  <= '0;
                        state <= WAIT_BTN;
                        if (err_count != 8'hFF)
                            err_count <= err_count + 8'd1;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                HOLD: begin
                    tcnt <= '0;
                    if (report_ready) begin
                        report_valid <= 1'b0;
                        rx_ready     <= 1'b1;
                        state        <= WAIT_BTN;
                    end
                end
            endcase
            // home overrides any same-cycle position update
            if (home) begin
                pos_x <= '0;
                pos_y <= '0;
            end
        end
    end

endmodule

// File: tb/tb_hid_report_parser.sv
// Randomised scoreboard bench for hid_report_parser.
// Stimulus pushes expected reports; a monitor pops and compares.
module tb_hid_report_parser;

    localparam int TC = 16;
    localparam int MX = 1919;
    localparam int MY = 1079;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        report_valid;
    logic        report_ready;
    logic [2:0]  buttons;
    logic [7:0]  dx;
    logic [7:0]  dy;
    logic [2:0]  btn_press;
    logic [11:0] pos_x;
    logic [11:0] pos_y;
    logic        home;
    logic [7:0]  err_count;

    hid_report_parser #(
        .TIMEOUT_CYC(TC),
        .POS_W(12),
        .MAX_X(MX),
        .MAX_Y(MY)
    ) dut (
        .clk(clk),
        .rst(rst),
        .rx_data(rx_data),
        .rx_valid(rx_valid),
        .rx_ready(rx_ready),
        .report_valid(report_valid),
        .report_ready(report_ready),
        .buttons(buttons),
        .dx(dx),
        .dy(dy),
        .btn_press(btn_press),
        .pos_x(pos_x),
        .pos_y(pos_y),
        .home(home),
        .err_count(err_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  b;
        logic [2:0]  p;
        logic [7:0]  x;
        logic [7:0]  y;
        logic [11:0] px;
        logic [11:0] py;
    } exp_t;

    exp_t q[$];
    exp_t held;
    int   total = 0;
    int   bad = 0;
    int   rr_mode = 0;

    // Reference model state
    int   m_px = 0;
    int   m_py = 0;
    int   m_err = 0;
    logic [2:0] m_prev = 3'd0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     name, act, expv, $time);
        end
    endtask

    function automatic int clampi(input int v, input int mx);
        if (v < 0) return 0;
        if (v > mx) return mx;
        return v;
    endfunction

    always @(posedge clk) begin
        #1;
        case (rr_mode)
            1: report_ready = 1'b0;
            2: report_ready = 1'b1;
            default: report_ready = ($urandom_range(3) != 0);
        endcase
    end

    // Monitor
    logic pv = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            pv = 1'b0;
        end else begin
            if (report_valid && !pv) begin
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_report at %0t", $time);
                end else begin
                    held = q.pop_front();
                    chk("buttons", 32'(buttons), 32'(held.b));
                    chk("dx", 32'(dx), 32'(held.x));
                    chk("dy", 32'(dy), 32'(held.y));
                    chk("btn_press", 32'(btn_press), 32'(held.p));
                    chk("pos_x", 32'(pos_x), 32'(held.px));
                    chk("pos_y", 32'(pos_y), 32'(held.py));
                    chk("hold_rx_ready", 32'(rx_ready), 32'd0);
                end
            end else if (report_valid && pv) begin
                chk("stable_buttons", 32'(buttons), 32'(held.b));
                chk("stable_dx", 32'(dx), 32'(held.x));
                chk("stable_dy", 32'(dy), 32'(held.y));
                chk("stable_pos_x", 32'(pos_x), 32'(held.px));
                chk("press_single", 32'(btn_press), 32'd0);
                chk("hold_rx_ready", 32'(rx_ready), 32'd0);
            end
            pv = report_valid;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int n;
        rx_data  = b;
        rx_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!rx_ready && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (!rx_ready) begin
            total++;
            bad++;
            $display("FAIL rx_ready_timeout got 0 expected 1 at %0t", $time);
        end
        @(posedge clk);
        #1 rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [2:0] b, input logic [7:0] x,
                              input logic [7:0] y, input bit hm);
        exp_t e;
        byte sx;
        byte sy;
        sx = x;
        sy = y;
        e.b = b;
        e.x = x;
        e.y = y;
        e.p = b & ~m_prev;
        m_prev = b;
        m_px = clampi(m_px + int'(sx), MX);
        m_py = clampi(m_py + int'(sy), MY);
        if (hm) begin
            m_px = 0;
            m_py = 0;
        end
        e.px = 12'(m_px);
        e.py = 12'(m_py);
        q.push_back(e);
        send_byte({5'd0, b});
        send_byte(x);
        home = hm;
        send_byte(y);
        home = 1'b0;
    endtask

    task automatic bad_byte(input logic [7:0] b);
        if (m_err < 255) m_err++;
        send_byte(b);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q.size() != 0 || report_valid) && n < 500) begin
            n++;
            @(posedge clk);
        end
        #1;
        if (q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain got %0d pending expected 0", q.size());
        end
    endtask

    initial begin
        int n;
        logic [7:0] e0;
        rst = 1'b1;
        rx_valid = 1'b0;
        rx_data = 8'd0;
        home = 1'b0;
        report_ready = 1'b0;
        idle(3);
        rst = 1'b0;
        #1;
        chk("rst_rx_ready", 32'(rx_ready), 32'd1);
        chk("rst_valid", 32'(report_valid), 32'd0);
        chk("rst_pos_x", 32'(pos_x), 32'd0);
        chk("rst_err", 32'(err_count), 32'd0);

        // Basic frame
        rr_mode = 2;
        send_frame(3'd1, 8'h05, 8'hFD, 1'b0);
        drain();

        // Clamp: climb to 1910, then overshoot, then drive far negative
        rr_mode = 0;
        for (int i = 0; i < 15; i++) send_frame(3'd0, 8'd127, 8'd0, 1'b0);
        send_frame(3'd0, 8'd0, 8'd0, 1'b0);
        drain();
        for (int i = 0; i < 0; i++) send_frame(3'd0, 8'd0, 8'd0, 1'b0);
        send_frame(3'd2, 8'd20, 8'd0, 1'b0);
        drain();
        chk("clamp_hi", 32'(pos_x), 32'(MX));
        for (int i = 0; i < 16; i++) send_frame(3'd0, 8'h80, 8'd0, 1'b0);
        drain();
        chk("clamp_lo", 32'(pos_x), 32'd0);

        // Backpressure then back-to-back byte0
        rr_mode = 1;
        send_frame(3'd4, 8'd3, 8'd9, 1'b0);
        n = 0;
        while (!report_valid && n < 50) begin
            n++;
            @(negedge clk);
        end
        chk("bp_valid", 32'(report_valid), 32'd1);
        repeat (10) @(negedge clk);
        chk("bp_still_valid", 32'(report_valid), 32'd1);
        rr_mode = 2;
        e0 = 8'd3;
        begin
            exp_t e;
            e.b = 3'd3;
            e.p = 3'd3 & ~m_prev;
            m_prev = 3'd3;
            e.x = 8'd1;
            e.y = 8'd1;
            m_px = clampi(m_px + 1, MX);
            m_py = clampi(m_py + 1, MY);
            e.px = 12'(m_px);
            e.py = 12'(m_py);
            q.push_back(e);
        end
        send_byte(e0);
        send_byte(8'd1);
        send_byte(8'd1);
        drain();

        // Timeout on a partial frame
        send_byte(8'h00);
        send_byte(8'h10);
        if (m_err < 255) m_err++;
        repeat (TC - 1) @(posedge clk);
        #1 chk("tout_early", 32'(err_count), 32'(m_err - 1));
        @(posedge clk);
        #1 chk("tout_err", 32'(err_count), 32'(m_err));
        send_frame(3'd1, 8'd2, 8'd2, 1'b0);
        drain();

        // Bad padding
        bad_byte(8'h81);
        chk("pad_err", 32'(err_count), 32'(m_err));
        send_frame(3'd0, 8'hFF, 8'd4, 1'b0);
        drain();
        for (int i = 0; i < 300; i++)
            bad_byte(8'(8'h08 | 8'($urandom_range(255))));
        idle(1);
        chk("err_sat", 32'(err_count), 32'd255);

        // Random frames with random inter-byte gaps below the timeout
        rr_mode = 0;
        for (int i = 0; i < 40; i++) begin
            send_frame(3'($urandom_range(7)), 8'($urandom_range(255)),
                       8'($urandom_range(255)), 1'b0);
            idle($urandom_range(3));
        end
        drain();

        // rst in WAIT_Y
        send_byte(8'h07);
        send_byte(8'h11);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        m_px = 0;
        m_py = 0;
        m_err = 0;
        m_prev = 3'd0;
        chk("rst2_rx_ready", 32'(rx_ready), 32'd1);
        chk("rst2_valid", 32'(report_valid), 32'd0);
        chk("rst2_buttons", 32'(buttons), 32'd0);
        chk("rst2_err", 32'(err_count), 32'd0);
        send_frame(3'd5, 8'd10, 8'd20, 1'b0);
        drain();

        // home together with a dx=+7 update
        send_frame(3'd1, 8'd7, 8'd0, 1'b1);
        drain();
        chk("home_x", 32'(pos_x), 32'd0);
        chk("home_y", 32'(pos_y), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
